// File: rtl/rabb_slab_reduce_if.sv
// Slab-reduce handshake bundle: beat input stream and held result output.
// Optional feature in the consumer: RABB_SLAB_SWAP_EN (see rabb_slab_reduce).
interface rabb_slab_reduce_if #(
   parameter int WIDTH = 34
);
   logic             in_valid;
   logic             in_ready;
   logic             in_last;
   logic [WIDTH:0]   t_lo;
   logic [WIDTH:0]   t_hi;
   logic             out_valid;
   logic             out_ready;
   logic             hit;
   logic [WIDTH:0]   t_near;
   logic [WIDTH:0]   t_far;
   logic             axis_err;

   // Producer of beats / consumer of results.
   modport master (
      output in_valid, in_last, t_lo, t_hi, out_ready,
      input  in_ready, out_valid, hit, t_near, t_far, axis_err
   );

   // The reduction block.
   modport slave (
      input  in_valid, in_last, t_lo, t_hi, out_ready,
      output in_ready, out_valid, hit, t_near, t_far, axis_err
   );
endinterface

// File: rtl/rabb_slab_reduce.sv
// Ray/AABB slab reduction over FloPoCo-format distances.
// Folds up to three per-axis (t_lo, t_hi) beats into max-entry / min-exit
// and reports whether the ray hits the box.
// Macro RABB_SLAB_SWAP_EN: when defined, each beat's t_lo/t_hi are swapped
// if t_lo > t_hi (negative ray direction) before reduction.
module rabb_slab_reduce #(
   parameter int WIDTH = 34
) (
   input logic                clk,
   input logic                rst,
   rabb_slab_reduce_if.slave  slab
);

   localparam int MAGW = WIDTH - 2;   // exponent + fraction bits

   // Order key of +0: class 2, zero magnitude.
   localparam logic [WIDTH:0] ZERO_KEY = {3'd2, {MAGW{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_OUT   = 2'd2
   } state_t;

   // Maps an operand to an unsigned key whose integer order matches the
   // numeric order: -inf < -normal < 0 < +normal < +inf. Negative normals
   // invert their magnitude so larger magnitudes sort lower. NaN gets the
   // top class; its position is irrelevant because NaN forces a miss.
   function automatic logic [WIDTH:0] ord_key(input logic [WIDTH:0] v);
      logic [WIDTH:0] k;
      case (v[WIDTH:WIDTH-1])
         2'b00:   k = {3'd2, {MAGW{1'b0}}};
         2'b01:   k = v[WIDTH-2] ? {3'd1, ~v[MAGW-1:0]} : {3'd3, v[MAGW-1:0]};
         2'b10:   k = v[WIDTH-2] ? {3'd0, {MAGW{1'b0}}} : {3'd4, {MAGW{1'b0}}};
         default: k = {3'd7, {MAGW{1'b0}}};
      endcase
      return k;
   endfunction

   function automatic logic is_nan(input logic [WIDTH:0] v);
      return (v[WIDTH:WIDTH-1] == 2'b11);
   endfunction

   state_t          state_q;
   logic [WIDTH:0]  near_q, far_q;
   logic            nan_q;
   logic [1:0]      count_q;
   logic            hit_q;
   logic            axis_err_q;
   logic            out_valid_q;
   logic            in_ready_q;

   logic [WIDTH:0]  lo_s, hi_s;
   logic [WIDTH:0]  near_d, far_d;
   logic            nan_d;
   logic            hit_d;
   logic            accept_s;

   assign accept_s = slab.in_valid & in_ready_q;

   // Beat orientation, running max/min fold and hit decision for this beat.
   always_comb begin
      lo_s = slab.t_lo;
      hi_s = slab.t_hi;
`ifdef RABB_SLAB_SWAP_EN
      if (ord_key(slab.t_hi) < ord_key(slab.t_lo)) begin
         lo_s = slab.t_hi;
         hi_s = slab.t_lo;
      end else begin
         lo_s = slab.t_lo;
         hi_s = slab.t_hi;
      end
`endif
      if (state_q == ST_IDLE) begin
         near_d = lo_s;
         far_d  = hi_s;
         nan_d  = is_nan(lo_s) | is_nan(hi_s);
      end else begin
         // Strict compares: on a tie the stored operand is kept.
         near_d = (ord_key(lo_s) > ord_key(near_q)) ? lo_s : near_q;
         far_d  = (ord_key(hi_s) < ord_key(far_q))  ? hi_s : far_q;
         nan_d  = nan_q | is_nan(lo_s) | is_nan(hi_s);
      end
      hit_d = ~nan_d
            & (ord_key(near_d) <= ord_key(far_d))
            & (ord_key(far_d) >= ZERO_KEY);
   end

   // Ray FSM: accumulate beats, publish result, hold until consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         near_q      <= {(WIDTH+1){1'b0}};
         far_q       <= {(WIDTH+1){1'b0}};
         nan_q       <= 1'b0;
         count_q     <= 2'd0;
         hit_q       <= 1'b0;
         axis_err_q  <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_ACCUM: begin
               if (accept_s) begin
                  near_q  <= near_d;
                  far_q   <= far_d;
                  nan_q   <= nan_d;
                  count_q <= count_q + 2'd1;
                  if ((state_q == ST_ACCUM) && (count_q == 2'd3)) begin
                     // Fourth beat of a ray: too many axes, force a miss.
                     state_q     <= ST_OUT;
                     axis_err_q  <= 1'b1;
                     hit_q       <= 1'b0;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                  end else if (slab.in_last) begin
                     state_q     <= ST_OUT;
                     hit_q       <= hit_d;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                  end else begin
                     state_q <= ST_ACCUM;
                  end
               end
            end
            ST_OUT: begin
               if (slab.out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  nan_q       <= 1'b0;
                  count_q     <= 2'd0;
                  axis_err_q  <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               nan_q       <= 1'b0;
               count_q     <= 2'd0;
               axis_err_q  <= 1'b0;
               hit_q       <= 1'b0;
            end
         endcase
      end
   end

   assign slab.in_ready  = in_ready_q;
   assign slab.out_valid = out_valid_q;
   assign slab.hit       = hit_q;
   assign slab.t_near    = near_q;
   assign slab.t_far     = far_q;
   assign slab.axis_err  = axis_err_q;

endmodule

// File: tb/tb_rabb_slab_reduce.sv
// Self-checking bench for rabb_slab_reduce: directed rays plus random rays
// compared against a real-valued reference model.
module tb_rabb_slab_reduce;

   localparam int W = 34;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   logic [W:0] q_lo[$];
   logic [W:0] q_hi[$];

   rabb_slab_reduce_if #(.WIDTH(W)) slab ();

   rabb_slab_reduce #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .slab (slab)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Numeric value of an operand (infinities as huge finite values).
   function automatic real val(input logic [W:0] v);
      real m;
      int  e;
      case (v[W:W-1])
         2'b00: return 0.0;
         2'b01: begin
            m = 1.0 + real'(v[20:0]) / 2097152.0;
            e = int'(v[31:21]) - 1023;
            while (e > 0) begin m = m * 2.0; e--; end
            while (e < 0) begin m = m / 2.0; e++; end
            return v[32] ? -m : m;
         end
         2'b10: return v[32] ? -1.0e300 : 1.0e300;
         default: return 0.0;
      endcase
   endfunction

   function automatic logic is_nan(input logic [W:0] v);
      return (v[W:W-1] == 2'b11);
   endfunction

   // Encode a real value (exactly representable) as a normal or zero.
   function automatic logic [W:0] enc(input real r);
      real  m;
      int   e;
      logic s;
      if (r == 0.0) return {(W+1){1'b0}};
      s = (r < 0.0);
      m = s ? -r : r;
      e = 1023;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      return {2'b01, s, 11'(e), 21'($rtoi((m - 1.0) * 2097152.0))};
   endfunction

   function automatic logic [W:0] rnd_val();
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8)       return {2'b00, 1'($urandom_range(0, 1)), 32'd0};
      else if (r < 12) return {2'b10, 1'($urandom_range(0, 1)), 32'd0};
      else if (r < 15) return {2'b11, 1'b0, 32'($urandom)};
      else return {2'b01, 1'($urandom_range(0, 1)), 11'($urandom_range(1018, 1028)),
                   21'($urandom_range(0, 3) << 19)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One beat, driven just after a rising edge and accepted on the next.
   task automatic beat(input logic [W:0] lo, input logic [W:0] hi, input logic last);
      slab.in_valid = 1'b1;
      slab.t_lo     = lo;
      slab.t_hi     = hi;
      slab.in_last  = last;
      @(posedge clk); #1;
      slab.in_valid = 1'b0;
      slab.in_last  = 1'b0;
   endtask

   // Drive the ray in q_lo/q_hi, check the result against the model,
   // optionally stall the consumer, then complete the handshake.
   task automatic run_ray(input string tag, input int stall);
      logic [W:0] lo, hi, t, near, far;
      logic       nan, ehit;
      int         n;
      n    = q_lo.size();
      nan  = 1'b0;
      near = '0;
      far  = '0;
      for (int i = 0; i < n; i++) begin
         lo = q_lo[i];
         hi = q_hi[i];
`ifdef RABB_SLAB_SWAP_EN
         if (!is_nan(lo) && !is_nan(hi) && (val(hi) < val(lo))) begin
            t = lo; lo = hi; hi = t;
         end
`endif
         if (is_nan(lo) || is_nan(hi)) nan = 1'b1;
         if (i == 0) begin
            near = lo;
            far  = hi;
         end else begin
            if (val(lo) > val(near)) near = lo;
            if (val(hi) < val(far))  far  = hi;
         end
      end
      ehit = !nan && (val(near) <= val(far)) && (val(far) >= 0.0);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_in_ready"}, 64'(slab.in_ready), 64'd1);
         beat(q_lo[i], q_hi[i], (i == n - 1));
      end
      chk({tag, "_out_valid"}, 64'(slab.out_valid), 64'd1);
      chk({tag, "_hit"}, 64'(slab.hit), 64'(ehit));
      chk({tag, "_axis_err"}, 64'(slab.axis_err), 64'd0);
      if (!nan) begin
         chk({tag, "_t_near"}, 64'(slab.t_near), 64'(near));
         chk({tag, "_t_far"}, 64'(slab.t_far), 64'(far));
      end
      if (stall > 0) begin
         slab.in_valid = 1'b1;
         slab.in_last  = 1'b1;
         slab.t_lo     = rnd_val();
         slab.t_hi     = rnd_val();
         repeat (stall) begin @(posedge clk); #1; end
         slab.in_valid = 1'b0;
         slab.in_last  = 1'b0;
         chk({tag, "_stall_in_ready"}, 64'(slab.in_ready), 64'd0);
         chk({tag, "_stall_valid"}, 64'(slab.out_valid), 64'd1);
         chk({tag, "_stall_hit"}, 64'(slab.hit), 64'(ehit));
         if (!nan) chk({tag, "_stall_t_near"}, 64'(slab.t_near), 64'(near));
      end
      slab.out_ready = 1'b1;
      @(posedge clk); #1;
      slab.out_ready = 1'b0;
      chk({tag, "_released"}, 64'(slab.out_valid), 64'd0);
      chk({tag, "_ready_again"}, 64'(slab.in_ready), 64'd1);
      q_lo.delete();
      q_hi.delete();
   endtask

   initial begin
      logic [W:0] a, b, nz, pz, qnan;
      n_chk          = 0;
      n_pass         = 0;
      rst            = 1'b1;
      slab.in_valid  = 1'b0;
      slab.in_last   = 1'b0;
      slab.t_lo      = '0;
      slab.t_hi      = '0;
      slab.out_ready = 1'b0;
      nz   = {2'b00, 1'b1, 32'd0};
      pz   = {2'b00, 1'b0, 32'd0};
      qnan = {2'b11, 1'b0, 32'h1234};

      // Reset state
      #12;
      chk("rst_out_valid", 64'(slab.out_valid), 64'd0);
      chk("rst_hit", 64'(slab.hit), 64'd0);
      chk("rst_axis_err", 64'(slab.axis_err), 64'd0);
      chk("rst_t_near", 64'(slab.t_near), 64'd0);
      chk("rst_t_far", 64'(slab.t_far), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_ready", 64'(slab.in_ready), 64'd1);

      // Three-axis hit with explicit expected values
      q_lo = '{enc(1.0), enc(2.0), enc(0.5)};
      q_hi = '{enc(4.0), enc(5.0), enc(3.0)};
      beat(q_lo[0], q_hi[0], 1'b0);
      beat(q_lo[1], q_hi[1], 1'b0);
      chk("hit3_not_yet", 64'(slab.out_valid), 64'd0);
      beat(q_lo[2], q_hi[2], 1'b1);
      chk("hit3_valid", 64'(slab.out_valid), 64'd1);
      chk("hit3_t_near", 64'(slab.t_near), 64'(enc(2.0)));
      chk("hit3_t_far", 64'(slab.t_far), 64'(enc(3.0)));
      chk("hit3_hit", 64'(slab.hit), 64'd1);
      slab.out_ready = 1'b1;
      @(posedge clk); #1;
      slab.out_ready = 1'b0;
      q_lo.delete();
      q_hi.delete();

      // Disjoint slabs: near beyond far
      q_lo = '{enc(1.0), enc(3.0), enc(0.0)};
      q_hi = '{enc(2.0), enc(4.0), enc(5.0)};
      run_ray("disjoint", 0);

      // Box behind the ray origin, then signed-zero single beat
      q_lo = '{enc(-5.0), enc(-4.0), enc(-3.0)};
      q_hi = '{enc(-1.0), enc(-2.0), enc(-1.0)};
      run_ray("behind", 1);
      q_lo = '{nz};
      q_hi = '{pz};
      run_ray("zero", 0);

      // NaN is sticky within a ray and cleared for the next one
      q_lo = '{qnan, enc(1.0)};
      q_hi = '{enc(4.0), enc(2.0)};
      run_ray("nan", 0);
      q_lo = '{enc(1.0)};
      q_hi = '{enc(2.0)};
      run_ray("after_nan", 0);

      // Four beats without last: forced error result, held under stall
      for (int i = 0; i < 3; i++) beat(enc(1.0), enc(2.0), 1'b0);
      chk("err_not_yet", 64'(slab.out_valid), 64'd0);
      beat(enc(1.0), enc(2.0), 1'b0);
      chk("err_valid", 64'(slab.out_valid), 64'd1);
      chk("err_axis_err", 64'(slab.axis_err), 64'd1);
      chk("err_hit", 64'(slab.hit), 64'd0);
      a = slab.t_near;
      b = slab.t_far;
      slab.in_valid = 1'b1;
      slab.in_last  = 1'b1;
      slab.t_lo     = enc(8.0);
      slab.t_hi     = enc(9.0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("err_hold_in_ready", 64'(slab.in_ready), 64'd0);
         chk("err_hold_valid", 64'(slab.out_valid), 64'd1);
         chk("err_hold_axis_err", 64'(slab.axis_err), 64'd1);
         chk("err_hold_hit", 64'(slab.hit), 64'd0);
         chk("err_hold_t_near", 64'(slab.t_near), 64'(a));
         chk("err_hold_t_far", 64'(slab.t_far), 64'(b));
      end
      slab.in_valid  = 1'b0;
      slab.in_last   = 1'b0;
      slab.out_ready = 1'b1;
      @(posedge clk); #1;
      slab.out_ready = 1'b0;
      chk("err_cleared", 64'(slab.axis_err), 64'd0);
      q_lo = '{enc(0.5), enc(1.0)};
      q_hi = '{enc(2.0), enc(3.0)};
      run_ray("after_err", 0);

      // Reset in the middle of a ray
      beat(enc(1.0), enc(2.0), 1'b0);
      beat(enc(1.5), enc(2.0), 1'b0);
      rst = 1'b1;
      #2;
      chk("midray_rst_valid", 64'(slab.out_valid), 64'd0);
      chk("midray_rst_t_near", 64'(slab.t_near), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midray_rst_ready", 64'(slab.in_ready), 64'd1);
      beat(enc(1.0), enc(2.0), 1'b1);
      chk("post_rst_t_near", 64'(slab.t_near), 64'(enc(1.0)));
      chk("post_rst_t_far", 64'(slab.t_far), 64'(enc(2.0)));
      chk("post_rst_hit", 64'(slab.hit), 64'd1);

      // Reset while a result is held
      rst = 1'b1;
      #2;
      chk("out_rst_valid", 64'(slab.out_valid), 64'd0);
      chk("out_rst_hit", 64'(slab.hit), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("out_rst_ready", 64'(slab.in_ready), 64'd1);

      // Reversed slab: swapped when the feature is built in, a miss otherwise
      beat(enc(4.0), enc(1.0), 1'b1);
`ifdef RABB_SLAB_SWAP_EN
      chk("rev_t_near", 64'(slab.t_near), 64'(enc(1.0)));
      chk("rev_t_far", 64'(slab.t_far), 64'(enc(4.0)));
      chk("rev_hit", 64'(slab.hit), 64'd1);
`else
      chk("rev_t_near", 64'(slab.t_near), 64'(enc(4.0)));
      chk("rev_t_far", 64'(slab.t_far), 64'(enc(1.0)));
      chk("rev_hit", 64'(slab.hit), 64'd0);
`endif
      slab.out_ready = 1'b1;
      @(posedge clk); #1;
      slab.out_ready = 1'b0;

      // Random rays against the reference model, back to back
      for (int r = 0; r < 40; r++) begin
         int n;
         n = int'($urandom_range(1, 3));
         for (int i = 0; i < n; i++) begin
            a = rnd_val();
            b = rnd_val();
            if ($urandom_range(0, 1) == 1 && !is_nan(a) && !is_nan(b) && (val(b) < val(a))) begin
               q_lo.push_back(b);
               q_hi.push_back(a);
            end else begin
               q_lo.push_back(a);
               q_hi.push_back(b);
            end
         end
         run_ray("rand", int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rabb_slab_reduce.md
RABB_SLAB_REDUCE -- requirements
Module: rabb_slab_reduce

Interface
REQ-001 Parameter: WIDTH, default 34, index of MSB of FloPoCo 11/21 operand (operand is WIDTH+1 = 35 bits).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  slab beat present.
REQ-005 in_ready  output  1  block accepts beat when in_valid & in_ready.
REQ-006 in_last  input  1  marks final axis beat of a ray.
REQ-007 t_lo  input  WIDTH+1  per-axis slab entry distance.
REQ-008 t_hi  input  WIDTH+1  per-axis slab exit distance.
REQ-009 out_valid  output  1  result held for consumer.
REQ-010 out_ready  input  1  consumer accepts result when out_valid & out_ready.
REQ-011 hit  output  1  ray intersects box.
REQ-012 t_near  output  WIDTH+1  reduced max of entry distances.
REQ-013 t_far  output  WIDTH+1  reduced min of exit distances.
REQ-014 axis_err  output  1  set when a ray had more than 3 beats before in_last.

Function
REQ-015 Operand fields: [WIDTH:WIDTH-1] exception (00 zero, 01 normal, 10 inf, 11 NaN), [WIDTH-2] sign, [WIDTH-3:21] exponent, [20:0] fraction.
REQ-016 Ordering: -inf < negative normals < +0 = -0 < positive normals < +inf; normals ordered by {exponent,fraction} magnitude, reversed when negative.
REQ-017 Any NaN operand in a ray sets sticky nan flag; ray result is hit=0.
REQ-018 FSM states: IDLE, ACCUM, OUT.
REQ-019 IDLE: in_ready=1; accepted beat loads t_near<=t_lo, t_far<=t_hi; next ACCUM, or OUT if in_last.
REQ-020 ACCUM: in_ready=1; accepted beat updates t_near<=max(t_near,t_lo), t_far<=min(t_far,t_hi); ties keep the stored value; next OUT if in_last.
REQ-021 Beat count per ray 1..3; a 4th beat without in_last forces transition to OUT with axis_err=1 and hit=0; beat is consumed.
REQ-022 Transition to OUT computes hit = !nan & (t_near <= t_far) & (t_far >= +0), using post-update values, registered same edge.
REQ-023 OUT: in_ready=0, out_valid=1; t_near, t_far, hit, axis_err stable until out_ready; on out_ready return to IDLE, clearing nan, count, axis_err.
REQ-024 Latency: result out_valid asserts the cycle after the in_last beat is accepted; one beat accepted per cycle; no bubble required between rays beyond the OUT handshake cycle.
REQ-025 in_valid with in_ready=0 is ignored; inputs need not be held stable by the block.
REQ-026 Comparisons are combinational, single cycle, no external subtractor.

Reset
REQ-027 rst asserted forces IDLE immediately, mid-ray or mid-OUT, discarding partial state.
REQ-028 Reset values: out_valid=0, hit=0, axis_err=0, t_near=0, t_far=0, nan=0, count=0; in_ready=1 after deassertion.

Configuration
REQ-029 Macro RABB_SLAB_SWAP_EN defined: each beat's t_lo/t_hi are swapped before reduction when t_lo > t_hi (negative ray direction).
REQ-030 RABB_SLAB_SWAP_EN undefined: operands used as given; t_lo > t_hi on an axis yields hit=0 through REQ-022.

Verification
REQ-031 Beats (1,4),(2,5),(0.5,3) last on 3rd -> out_valid next cycle, t_near=2, t_far=3, hit=1.
REQ-032 Beats (1,2),(3,4),(0,5) -> t_near=3, t_far=2, hit=0.
REQ-033 Beats (-5,-1),(-4,-2),(-3,-1) -> t_far=-2 < 0, hit=0; (-0,+0) single beat last -> hit=1.
REQ-034 Beat (NaN,4) then (1,2) last -> hit=0; next ray (1,2) last -> hit=1 (nan cleared).
REQ-035 Four beats without in_last -> axis_err=1, hit=0 after 4th; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0.
REQ-036 rst pulse after 2nd beat -> out_valid=0, IDLE; new ray (1,2) last -> t_near=1, t_far=2, hit=1; with RABB_SLAB_SWAP_EN, beat (4,1) last -> t_near=1, t_far=4, hit=1.
